// File: rtl/retire_queue.sv
// Retire queue: circular buffer of in-flight instructions, committed in order from the head.
// Latency: writeback-to-commit 1 cycle (0 with RETIRE_QUEUE_WB_BYPASS_EN defined); issue exceptions commit 1 cycle after issue.
// Backpressure: issue_ready_o drops when the registered count is full or flush_i is high; commit ports hold until acked.
module retire_queue #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          flush_i,
    input  logic                                          issue_valid_i,
    output logic                                          issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o,
    input  logic [63:0]                                   issue_pc_i,
    input  logic [16:0]                                   issue_ctrl_i,
    input  logic [6:0]                                    issue_ex_i,
    input  logic                                          wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0]                      wb_trans_id_i,
    input  logic [63:0]                                   wb_result_i,
    input  logic [6:0]                                    wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]                    commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][63:0]              commit_pc_o,
    output logic [NR_COMMIT_PORTS-1:0][16:0]              commit_ctrl_o,
    output logic [NR_COMMIT_PORTS-1:0][63:0]              commit_result_o,
    output logic [NR_COMMIT_PORTS-1:0][6:0]               commit_ex_o,
    output logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] commit_trans_id_o,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
    output logic [TRANS_ID_BITS:0]                        count_o
);

    localparam logic [TRANS_ID_BITS:0] LP_FULL = (TRANS_ID_BITS+1)'(NR_ENTRIES);

    // Entry payload (no reset needed: validity lives in r_alloc/r_done)
    logic [63:0]              r_pc     [NR_ENTRIES];
    logic [16:0]              r_ctrl   [NR_ENTRIES];
    logic [63:0]              r_result [NR_ENTRIES];
    logic [6:0]               r_ex     [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]    r_alloc;
    logic [NR_ENTRIES-1:0]    r_done;
    logic [TRANS_ID_BITS-1:0] r_head;
    logic [TRANS_ID_BITS-1:0] r_tail;
    logic [TRANS_ID_BITS:0]   r_count;

    logic                                          w_alloc;
    logic                                          w_wb_hit;
    logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] w_idx;
    logic [NR_COMMIT_PORTS-1:0]                    w_ret;
    logic [TRANS_ID_BITS:0]                        w_k;
    logic                                          w_chain;
    logic                                          w_run;
    logic                                          w_done_eff;

    // A retirement this cycle only frees a slot next cycle, so readiness uses the registered count.
    assign issue_ready_o    = (r_count < LP_FULL) & ~flush_i;
    assign issue_trans_id_o = r_tail;
    assign count_o          = r_count;
    assign w_alloc          = issue_valid_i & issue_ready_o & ~rst_i;
    // Late writebacks must not overwrite an issue-time exception, hence the not-done qualifier.
    assign w_wb_hit         = wb_valid_i & ~flush_i & ~rst_i & r_alloc[wb_trans_id_i] & ~r_done[wb_trans_id_i];

    // Present head+i on each commit port and find the leading run of acked valid ports.
    always_comb begin
        commit_valid_o    = '0;
        commit_pc_o       = '0;
        commit_ctrl_o     = '0;
        commit_result_o   = '0;
        commit_ex_o       = '0;
        commit_trans_id_o = '0;
        w_idx             = '0;
        w_ret             = '0;
        w_k               = '0;
        w_chain           = 1'b1;
        w_run             = 1'b1;
        w_done_eff        = 1'b0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_idx[i]             = r_head + TRANS_ID_BITS'(i);
            w_done_eff           = r_done[w_idx[i]];
            commit_pc_o[i]       = r_pc[w_idx[i]];
            commit_ctrl_o[i]     = r_ctrl[w_idx[i]];
            commit_result_o[i]   = r_result[w_idx[i]];
            commit_ex_o[i]       = r_ex[w_idx[i]];
            commit_trans_id_o[i] = w_idx[i];
`ifdef RETIRE_QUEUE_WB_BYPASS_EN
            if (w_wb_hit && (wb_trans_id_i == w_idx[i])) begin
                w_done_eff         = 1'b1;
                commit_result_o[i] = wb_result_i;
                commit_ex_o[i]     = wb_ex_i;
            end
`endif
            // A port is valid only if every older port is valid, so commits stay in order.
            w_chain           = w_chain & r_alloc[w_idx[i]] & w_done_eff & ~flush_i;
            commit_valid_o[i] = w_chain;
            w_run             = w_run & commit_ack_i[i] & w_chain;
            w_ret[i]          = w_run;
            w_k               = w_k + {{TRANS_ID_BITS{1'b0}}, w_run};
        end
    end

    // Payload writes for newly issued entries and accepted writebacks.
    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_pc[r_tail]     <= issue_pc_i;
            r_ctrl[r_tail]   <= issue_ctrl_i;
            r_ex[r_tail]     <= issue_ex_i;
            r_result[r_tail] <= '0;
        end
        if (w_wb_hit) begin
            r_result[wb_trans_id_i] <= wb_result_i;
            r_ex[wb_trans_id_i]     <= wb_ex_i;
        end
    end

    // Pointers, occupancy and per-entry state; reset and flush both empty the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else begin
            if (w_wb_hit) begin
                r_done[wb_trans_id_i] <= 1'b1;
            end
            if (w_alloc) begin
                r_alloc[r_tail] <= 1'b1;
                r_done[r_tail]  <= issue_ex_i[6];
                r_tail          <= r_tail + 1'b1;
            end
            // Retire clears last so a bypassed writeback cannot leave a stale done bit behind.
            for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
                if (w_ret[j]) begin
                    r_alloc[w_idx[j]] <= 1'b0;
                    r_done[w_idx[j]]  <= 1'b0;
                end
            end
            r_head  <= r_head + w_k[TRANS_ID_BITS-1:0];
            r_count <= r_count + {{TRANS_ID_BITS{1'b0}}, w_alloc} - w_k;
        end
    end

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue (8 entries, 2 commit ports, no writeback bypass).
// Inputs change on the falling edge; outputs are sampled 1 time unit later, before the next rising edge.
// Each table row is one cycle: inputs applied, then the pre-edge outputs compared to hand-computed values.
module tb_retire_queue;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [2:0]       issue_trans_id_o;
    logic [63:0]      issue_pc_i;
    logic [16:0]      issue_ctrl_i;
    logic [6:0]       issue_ex_i;
    logic             wb_valid_i;
    logic [2:0]       wb_trans_id_i;
    logic [63:0]      wb_result_i;
    logic [6:0]       wb_ex_i;
    logic [1:0]       commit_valid_o;
    logic [1:0][63:0] commit_pc_o;
    logic [1:0][16:0] commit_ctrl_o;
    logic [1:0][63:0] commit_result_o;
    logic [1:0][6:0]  commit_ex_o;
    logic [1:0][2:0]  commit_trans_id_o;
    logic [1:0]       commit_ack_i;
    logic [3:0]       count_o;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    retire_queue #(.NR_ENTRIES(8), .NR_COMMIT_PORTS(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_trans_id_o(issue_trans_id_o), .issue_pc_i(issue_pc_i),
        .issue_ctrl_i(issue_ctrl_i), .issue_ex_i(issue_ex_i),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
        .wb_result_i(wb_result_i), .wb_ex_i(wb_ex_i),
        .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
        .commit_ctrl_o(commit_ctrl_o), .commit_result_o(commit_result_o),
        .commit_ex_o(commit_ex_o), .commit_trans_id_o(commit_trans_id_o),
        .commit_ack_i(commit_ack_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        iv;
        logic [63:0] ipc;
        logic [6:0]  iex;
        logic        wv;
        logic [2:0]  wid;
        logic [63:0] wres;
        logic [6:0]  wex;
        logic [1:0]  ack;
        logic        fl;
        logic        rst;
        logic        e_rdy;
        logic [2:0]  e_tid;
        logic [1:0]  e_cv;
        logic [3:0]  e_cnt;
        logic        chk_res;
        logic [63:0] e_res;
        logic [6:0]  e_ex;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [63:0] ipc, input logic [6:0] iex,
                       input logic wv, input logic [2:0] wid, input logic [63:0] wres, input logic [6:0] wex,
                       input logic [1:0] ack, input logic fl, input logic rst,
                       input logic e_rdy, input logic [2:0] e_tid, input logic [1:0] e_cv, input logic [3:0] e_cnt,
                       input logic chk_res, input logic [63:0] e_res, input logic [6:0] e_ex);
        vec_t v;
        v.iv = iv; v.ipc = ipc; v.iex = iex; v.wv = wv; v.wid = wid; v.wres = wres; v.wex = wex;
        v.ack = ack; v.fl = fl; v.rst = rst; v.e_rdy = e_rdy; v.e_tid = e_tid; v.e_cv = e_cv;
        v.e_cnt = e_cnt; v.chk_res = chk_res; v.e_res = e_res; v.e_ex = e_ex;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, cur, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_pc_i = '0;
        issue_ctrl_i = 17'h5; issue_ex_i = '0; wb_valid_i = 1'b0; wb_trans_id_i = '0;
        wb_result_i = '0; wb_ex_i = '0; commit_ack_i = '0;
    endtask

    initial begin
        int cycles;
        idle_inputs();
        rst_i = 1'b1;

        //   iv ipc            iex    wv wid wres     wex    ack   fl rst | rdy tid cv     cnt chkres res       ex
        // single instruction: issue, writeback, commit one cycle later, ack
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 0, 2'b00, 0, 0, 64'h0,    7'h00);
        add(1, 64'h80000000,  7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 0, 2'b00, 0, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 1, 0, 64'h1234,7'h00, 2'b00, 0, 0,   1, 1, 2'b00, 1, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 1, 2'b01, 1, 1, 64'h1234, 7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b01, 0, 0,   1, 1, 2'b01, 1, 1, 64'h1234, 7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 1, 2'b00, 0, 0, 64'h0,    7'h00);
        // reset mid-run has priority over a pending issue
        add(1, 64'hdead,      7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 1,   1, 1, 2'b00, 0, 0, 64'h0,    7'h00);
        // fill all eight entries
        for (int i = 0; i < 8; i++)
            add(1, 64'h100 + 64'(4*i), 7'h00, 0, 0, 64'h0, 7'h00, 2'b00, 0, 0, 1, 3'(i), 2'b00, 4'(i), 0, 64'h0, 7'h00);
        // ninth request held while full; retire in the same cycle does not free the slot yet
        add(1, 64'h200,       7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   0, 0, 2'b00, 8, 0, 64'h0,    7'h00);
        add(1, 64'h200,       7'h00, 1, 0, 64'hAA,  7'h00, 2'b00, 0, 0,   0, 0, 2'b00, 8, 0, 64'h0,    7'h00);
        add(1, 64'h200,       7'h00, 0, 0, 64'h0,   7'h00, 2'b01, 0, 0,   0, 0, 2'b01, 8, 1, 64'hAA,   7'h00);
        add(1, 64'h200,       7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 0, 2'b00, 7, 0, 64'h0,    7'h00);
        // out-of-order writebacks: id2 then id1 (head is 1)
        add(0, 64'h0,         7'h00, 1, 2, 64'h22,  7'h00, 2'b00, 0, 0,   0, 1, 2'b00, 8, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   0, 1, 2'b00, 8, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 1, 1, 64'h11,  7'h00, 2'b00, 0, 0,   0, 1, 2'b00, 8, 0, 64'h0,    7'h00);
        // ack 2'b10 skips port 0: nothing retires
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b10, 0, 0,   0, 1, 2'b11, 8, 1, 64'h11,   7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   0, 1, 2'b11, 8, 1, 64'h11,   7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b11, 0, 0,   0, 1, 2'b11, 8, 1, 64'h11,   7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 1, 2'b00, 6, 0, 64'h0,    7'h00);
        // retire one more, leaving five, then flush with issue/wb/ack all active
        add(0, 64'h0,         7'h00, 1, 3, 64'h33,  7'h00, 2'b00, 0, 0,   1, 1, 2'b00, 6, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b01, 0, 0,   1, 1, 2'b01, 6, 1, 64'h33,   7'h00);
        add(1, 64'h300,       7'h00, 1, 4, 64'h44,  7'h00, 2'b01, 1, 0,   0, 1, 2'b00, 5, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 0, 2'b00, 0, 0, 64'h0,    7'h00);
        // issue-time exception: done immediately, later writeback ignored
        add(1, 64'h400,       7'h42, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 0, 2'b00, 0, 0, 64'h0,    7'h00);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 1, 2'b01, 1, 0, 64'h0,    7'h42);
        add(0, 64'h0,         7'h00, 1, 0, 64'h55,  7'h45, 2'b00, 0, 0,   1, 1, 2'b01, 1, 0, 64'h0,    7'h42);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 1, 2'b01, 1, 0, 64'h0,    7'h42);
        // ack on both ports with only port 0 valid retires exactly one
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b11, 0, 0,   1, 1, 2'b01, 1, 0, 64'h0,    7'h42);
        add(0, 64'h0,         7'h00, 0, 0, 64'h0,   7'h00, 2'b00, 0, 0,   1, 1, 2'b00, 0, 0, 64'h0,    7'h00);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cur           = i;
            rst_i         = vecs[i].rst;
            flush_i       = vecs[i].fl;
            issue_valid_i = vecs[i].iv;
            issue_pc_i    = vecs[i].ipc;
            issue_ex_i    = vecs[i].iex;
            wb_valid_i    = vecs[i].wv;
            wb_trans_id_i = vecs[i].wid;
            wb_result_i   = vecs[i].wres;
            wb_ex_i       = vecs[i].wex;
            commit_ack_i  = vecs[i].ack;
            #1;
            chk("ready", 64'(issue_ready_o), 64'(vecs[i].e_rdy));
            chk("trans_id", 64'(issue_trans_id_o), 64'(vecs[i].e_tid));
            chk("commit_valid", 64'(commit_valid_o), 64'(vecs[i].e_cv));
            chk("count", 64'(count_o), 64'(vecs[i].e_cnt));
            if (vecs[i].e_cv[0]) begin
                chk("commit_ex0", 64'(commit_ex_o[0]), 64'(vecs[i].e_ex));
                chk("commit_ctrl0", 64'(commit_ctrl_o[0]), 64'h5);
            end
            if (vecs[i].chk_res)
                chk("commit_result0", commit_result_o[0], vecs[i].e_res);
            @(negedge clk_i);
        end
        idle_inputs();

        // Writeback-to-commit latency: queue is empty with tail at 1.
        cur = 1000;
        issue_valid_i = 1'b1; issue_pc_i = 64'h500;
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_trans_id_i = 3'd1; wb_result_i = 64'h77;
        #1;
        chk("lat_same_cycle_valid", 64'(commit_valid_o), 64'h0);
        @(negedge clk_i);
        wb_valid_i = 1'b0;
        #1;
        cycles = 0;
        while (!commit_valid_o[0] && cycles < 5) begin
            @(negedge clk_i);
            #1;
            cycles++;
        end
        chk("lat_extra_cycles", 64'(cycles), 64'h0);
        chk("lat_result", commit_result_o[0], 64'h77);
        chk("lat_pc", commit_pc_o[0], 64'h500);
        chk("lat_trans_id", 64'(commit_trans_id_o[0]), 64'h1);
        commit_ack_i = 2'b01;
        @(negedge clk_i);
        commit_ack_i = 2'b00;
        #1;
        chk("lat_count_after_ack", 64'(count_o), 64'h0);
        chk("lat_valid_after_ack", 64'(commit_valid_o), 64'h0);
        chk("lat_next_id", 64'(issue_trans_id_o), 64'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_queue.md
RETIRE_QUEUE -- requirements
Module: retire_queue

Interface
- REQ-001 SHALL have parameter NR_ENTRIES, default 8, queue depth; power of two, minimum 4.
- REQ-002 SHALL have parameter NR_COMMIT_PORTS, default 2, head entries presented per cycle; range 1..2.
- REQ-003 SHALL have derived parameter TRANS_ID_BITS, default $clog2(NR_ENTRIES), entry index width.
- REQ-004 SHALL use one clock; reset is synchronous and active-high.
- REQ-005 clk_i  input  1  clock; all state updates on rising edge.
- REQ-006 rst_i  input  1  synchronous active-high reset.
- REQ-007 flush_i  input  1  discard all entries.
- REQ-008 issue_valid_i  input  1  allocation request.
- REQ-009 issue_ready_o  output  1  entry free and no flush.
- REQ-010 issue_trans_id_o  output  TRANS_ID_BITS  id of the entry allocated this cycle (tail pointer).
- REQ-011 issue_pc_i  input  64  instruction PC.
- REQ-012 issue_ctrl_i  input  17  {fu[3:0], op[7:0], rd[4:0]}.
- REQ-013 issue_ex_i  input  7  {valid, cause[5:0]} exception raised at issue.
- REQ-014 wb_valid_i  input  1  functional-unit writeback.
- REQ-015 wb_trans_id_i  input  TRANS_ID_BITS  target entry.
- REQ-016 wb_result_i  input  64  result data.
- REQ-017 wb_ex_i  input  7  {valid, cause[5:0]} exception raised at execute.
- REQ-018 commit_valid_o  output  NR_COMMIT_PORTS  port i holds a completed entry.
- REQ-019 commit_pc_o / commit_ctrl_o / commit_result_o / commit_ex_o  output  NR_COMMIT_PORTS x 64 / 17 / 64 / 7  fields of entry head+i.
- REQ-020 commit_trans_id_o  output  NR_COMMIT_PORTS x TRANS_ID_BITS  id of entry head+i.
- REQ-021 commit_ack_i  input  NR_COMMIT_PORTS  commit stage retires port i.
- REQ-022 count_o  output  TRANS_ID_BITS+1  occupied entries.

Function
- REQ-023 Circular buffer with head/tail pointers; both wrap modulo NR_ENTRIES.
- REQ-024 issue_ready_o = (registered count < NR_ENTRIES) & !flush_i; a retirement in the same cycle does not free a slot until the next cycle.
- REQ-025 On issue_valid_i & issue_ready_o: tail entry written, marked allocated, tail+1; done=1 immediately with ex recorded if issue_ex_i valid, else done=0.
- REQ-026 On wb_valid_i to an allocated, not-done entry: result stored, done=1, ex=wb_ex_i; writeback to an unallocated or done entry is ignored (issue exception preserved).
- REQ-027 commit_valid_o[i] = entry head+i allocated & done & (i==0 | commit_valid_o[i-1]); outputs from registered state only; writeback-to-commit latency 1 cycle.
- REQ-028 Retire count k = length of the leading run of (commit_ack_i & commit_valid_o) from port 0; head += k; acks outside that run are ignored.
- REQ-029 count_next = count + alloc - k; simultaneous issue and retire on any occupancy SHALL keep count exact.
- REQ-030 While flush_i high: commit_valid_o = 0, issue and writeback ignored; next cycle head = tail = count = 0, all entries unallocated.

Reset
- REQ-031 rst_i high at a rising edge: head = tail = count = 0, all allocated/done bits 0; commit_valid_o = 0, issue_ready_o = 1 (if flush_i low), issue_trans_id_o = 0, count_o = 0.
- REQ-032 Reset mid-operation discards all entries identically to flush, with priority over flush_i, issue and writeback.

Configuration
- REQ-033 Macro RETIRE_QUEUE_WB_BYPASS_EN defined: a same-cycle wb_valid_i to entry head+i forwards wb_result_i/wb_ex_i to port i and counts as done for REQ-027 (latency 0).
- REQ-034 Macro undefined: no forwarding; REQ-027 latency of 1 cycle holds.

Verification (NR_ENTRIES=8, NR_COMMIT_PORTS=2, no bypass)
- REQ-035 After reset, issue pc 0x80000000, rd 5 -> id 0; wb id 0 result 0x1234 at cycle t -> commit_valid_o=2'b01, result 0x1234 at t+1; ack 2'b01 -> count_o 0.
- REQ-036 8 issues, no wb -> count_o 8, issue_ready_o 0; 9th request held; wb id 0, then ack in the same cycle as the held request -> not accepted; accepted next cycle with id 0 (wrap).
- REQ-037 Issue 2, wb id 1 before id 0 -> commit_valid_o 2'b00; wb id 0 -> 2'b11 next cycle; ack 2'b11 -> count_o drops by 2.
- REQ-038 Both ports valid, commit_ack_i=2'b10 -> no retirement, count_o unchanged.
- REQ-039 Issue with issue_ex_i={1,6'd2} -> commit_valid_o[0]=1, commit_ex_o[0]={1,2} next cycle without wb; later wb to that id leaves ex unchanged.
- REQ-040 5 entries held, flush_i pulse -> commit_valid_o 0 that cycle; next cycle count_o 0; next issue returns id 0.
